// File: rtl/sw_reg_bank_wr.sv
// sw_reg_bank_wr: Wishbone bank of software-written control registers
// with per-register update strobes, pulse mode and a sticky status IRQ.
module sw_reg_bank_wr #(
  parameter int unsigned DEV_BASE_ADDR = 0,
  parameter int unsigned BUS_DATA_WIDTH = 32,
  parameter int unsigned BUS_ADDR_WIDTH = 8,
  parameter int unsigned NUM_REGS = 4,
  parameter logic [BUS_DATA_WIDTH-1:0] RESET_VAL = '0,
  parameter logic [NUM_REGS-1:0] PULSE_MASK = '0,
  parameter bit INT_EN = 1'b1
) (
  input  logic wb_clk_i,
  input  logic wb_rst_i,
  input  logic wbs_cyc_i,
  input  logic wbs_stb_i,
  input  logic wbs_we_i,
  input  logic [BUS_DATA_WIDTH/8-1:0] wbs_sel_i,
  input  logic [BUS_ADDR_WIDTH-1:0] wbs_adr_i,
  input  logic [BUS_DATA_WIDTH-1:0] wbs_dat_i,
  output logic [BUS_DATA_WIDTH-1:0] wbs_dat_o,
  output logic wbs_ack_o,
  output logic wbs_err_o,
  output logic wbs_int_o,
  output logic [NUM_REGS*BUS_DATA_WIDTH-1:0] fabric_data_o,
  output logic [NUM_REGS-1:0] fabric_upd_o
);

  localparam int unsigned W = BUS_DATA_WIDTH;
  localparam int unsigned AW = BUS_ADDR_WIDTH;
  localparam int unsigned B = W / 8;
  localparam int unsigned BL = $clog2(B);
  localparam logic [AW-1:0] BASE = AW'(DEV_BASE_ADDR);
  localparam logic [AW-1:0] ALIGN_MASK = AW'(B - 1);
  localparam logic [AW-1:0] STAT_IDX = AW'(NUM_REGS);

  logic [W-1:0] regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] status_q;
  logic [NUM_REGS-1:0] upd_q;
  logic [W-1:0] dat_q;
  logic ack_q;
  logic err_q;
  logic int_q;

  logic borrow;
  logic [AW-1:0] off;
  logic [AW-1:0] idx;
  logic valid;
  logic accept;
  logic any_sel;
  logic stat_hit;
  logic [W-1:0] wmask;
  logic [NUM_REGS-1:0] wr_hit;
  logic [NUM_REGS-1:0] clr_mask;
  logic [NUM_REGS-1:0] status_d;
  logic [W-1:0] rd_mux;

  // Decode: borrow flags addresses below base so they never wrap into range.
  always_comb begin
    {borrow, off} = {1'b0, wbs_adr_i} - {1'b0, BASE};
    idx = off >> BL;
    valid = !borrow && ((off & ALIGN_MASK) == '0) && (idx <= STAT_IDX);
    accept = wbs_cyc_i & wbs_stb_i & !ack_q & !err_q;
    any_sel = |wbs_sel_i;
    stat_hit = accept & valid & (idx == STAT_IDX);
    wmask = '0;
    for (int k = 0; k < int'(B); k++) begin
      wmask[k*8 +: 8] = {8{wbs_sel_i[k]}};
    end
    wr_hit = '0;
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      wr_hit[i] = accept & wbs_we_i & valid & any_sel & (idx == AW'(i));
    end
  end

  // Status next value: read-to-clear, write-1-to-clear by byte, set on writes.
  always_comb begin
    clr_mask = '0;
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      clr_mask[i] = stat_hit & wbs_we_i & wbs_dat_i[i] & wbs_sel_i[i/8];
    end
    if (stat_hit && !wbs_we_i) begin
      status_d = '0;
    end else begin
      status_d = (status_q & ~clr_mask) | wr_hit;
    end
  end

  // Readback mux for the addressed register or status.
  always_comb begin
    rd_mux = '0;
    if (idx == STAT_IDX) begin
      rd_mux[NUM_REGS-1:0] = status_q;
    end else begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        if (idx == AW'(i)) rd_mux = regs_q[i];
      end
    end
  end

  // Control registers: byte-merge on write; pulse-mode ones fall back to idle.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      for (int i = 0; i < int'(NUM_REGS); i++) regs_q[i] <= RESET_VAL;
    end else begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        if (wr_hit[i]) begin
          regs_q[i] <= (regs_q[i] & ~wmask) | (wbs_dat_i & wmask);
        end else if (PULSE_MASK[i]) begin
          regs_q[i] <= RESET_VAL;
        end
      end
    end
  end

  // Bus response, strobes, status and interrupt.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      dat_q <= '0;
      upd_q <= '0;
      status_q <= '0;
      int_q <= 1'b0;
    end else begin
      ack_q <= accept & valid;
      err_q <= accept & !valid;
      dat_q <= (accept && valid && !wbs_we_i) ? rd_mux : '0;
      upd_q <= wr_hit;
      status_q <= status_d;
      int_q <= INT_EN & (|status_q);
    end
  end

  // Fabric view of the register bank.
  always_comb begin
    fabric_data_o = '0;
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      fabric_data_o[i*W +: W] = regs_q[i];
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_err_o = err_q;
  assign wbs_dat_o = dat_q;
  assign wbs_int_o = int_q;
  assign fabric_upd_o = upd_q;

endmodule

// File: tb/tb_sw_reg_bank_wr.sv
// tb_sw_reg_bank_wr: directed bench for sw_reg_bank_wr
// (base 0x10, 4 x 32-bit regs, reg2 pulse mode, idle value 0xA5).
module tb_sw_reg_bank_wr;

  localparam logic [31:0] RV = 32'h0000_00A5;
  localparam logic [127:0] FAB_RST = {RV, RV, RV, RV};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cyc = 1'b0;
  logic stb = 1'b0;
  logic we = 1'b0;
  logic [3:0] sel = '0;
  logic [7:0] adr = '0;
  logic [31:0] wdat = '0;
  logic [31:0] rdat;
  logic ack;
  logic err;
  logic irq;
  logic [127:0] fab;
  logic [3:0] upd;

  int checks = 0;
  int errors = 0;

  logic a1, e1, i1, a2, e2, i2;
  logic [31:0] d1;
  logic [3:0] u1, u2;
  logic [127:0] f1, f2;

  sw_reg_bank_wr #(
    .DEV_BASE_ADDR(32'h10),
    .BUS_DATA_WIDTH(32),
    .BUS_ADDR_WIDTH(8),
    .NUM_REGS(4),
    .RESET_VAL(RV),
    .PULSE_MASK(4'b0100),
    .INT_EN(1'b1)
  ) dut (
    .wb_clk_i(clk),
    .wb_rst_i(rst),
    .wbs_cyc_i(cyc),
    .wbs_stb_i(stb),
    .wbs_we_i(we),
    .wbs_sel_i(sel),
    .wbs_adr_i(adr),
    .wbs_dat_i(wdat),
    .wbs_dat_o(rdat),
    .wbs_ack_o(ack),
    .wbs_err_o(err),
    .wbs_int_o(irq),
    .fabric_data_o(fab),
    .fabric_upd_o(upd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One single-beat access; captures cycle N+1 (x1) and N+2 (x2).
  task automatic acc(input logic w, input logic [7:0] a,
                     input logic [31:0] d, input logic [3:0] s);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    a1 = ack; e1 = err; d1 = rdat; u1 = upd; f1 = fab; i1 = irq;
    @(posedge clk); #1;
    a2 = ack; e2 = err; u2 = upd; f2 = fab; i2 = irq;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_ack", {127'b0, ack}, 128'd0);
    chk("rst_err", {127'b0, err}, 128'd0);
    chk("rst_int", {127'b0, irq}, 128'd0);
    chk("rst_dat", {96'b0, rdat}, 128'd0);
    chk("rst_upd", {124'b0, upd}, 128'd0);
    chk("rst_fab", fab, FAB_RST);

    // full write reg1
    acc(1'b1, 8'h14, 32'hDEADBEEF, 4'hF);
    chk("wr1_ack", {127'b0, a1}, 128'd1);
    chk("wr1_err", {127'b0, e1}, 128'd0);
    chk("wr1_upd", {124'b0, u1}, 128'd2);
    chk("wr1_fab", f1, {RV, RV, 32'hDEADBEEF, RV});
    chk("wr1_int_n1", {127'b0, i1}, 128'd0);
    chk("wr1_ack_n2", {127'b0, a2}, 128'd0);
    chk("wr1_upd_n2", {124'b0, u2}, 128'd0);
    chk("wr1_int_n2", {127'b0, i2}, 128'd1);
    acc(1'b0, 8'h14, 32'h0, 4'hF);
    chk("rd1_ack", {127'b0, a1}, 128'd1);
    chk("rd1_dat", {96'b0, d1}, {96'b0, 32'hDEADBEEF});

    // byte enables
    acc(1'b1, 8'h14, 32'h11223344, 4'b0101);
    chk("be_fab", f1, {RV, RV, 32'hDE22BE44, RV});
    chk("be_upd", {124'b0, u1}, 128'd2);
    acc(1'b1, 8'h14, 32'hFFFFFFFF, 4'b0000);
    chk("sel0_ack", {127'b0, a1}, 128'd1);
    chk("sel0_upd", {124'b0, u1}, 128'd0);
    chk("sel0_fab", f1, {RV, RV, 32'hDE22BE44, RV});

    // pulse-mode reg2
    acc(1'b1, 8'h18, 32'h5, 4'hF);
    chk("pls_fab_n1", f1, {RV, 32'h5, 32'hDE22BE44, RV});
    chk("pls_upd", {124'b0, u1}, 128'd4);
    chk("pls_fab_n2", f2, {RV, RV, 32'hDE22BE44, RV});
    acc(1'b0, 8'h18, 32'h0, 4'hF);
    chk("pls_rd", {96'b0, d1}, {96'b0, RV});

    // status read-to-clear (bits 1 and 2 set)
    acc(1'b0, 8'h20, 32'h0, 4'hF);
    chk("st_rd_a", {96'b0, d1}, 128'h6);
    chk("st_int_n2", {127'b0, i2}, 128'd0);
    acc(1'b0, 8'h20, 32'h0, 4'hF);
    chk("st_rd_b", {96'b0, d1}, 128'h0);
    acc(1'b1, 8'h10, 32'h0000_1234, 4'hF);
    acc(1'b1, 8'h1C, 32'hCAFE_0003, 4'hF);
    chk("st_int_set", {127'b0, i2}, 128'd1);
    acc(1'b0, 8'h20, 32'h0, 4'hF);
    chk("st_rd_9", {96'b0, d1}, 128'h9);
    acc(1'b0, 8'h20, 32'h0, 4'hF);
    chk("st_rd_0", {96'b0, d1}, 128'h0);

    // write-1-to-clear
    acc(1'b1, 8'h10, 32'h0000_1234, 4'hF);
    acc(1'b1, 8'h1C, 32'hCAFE_0003, 4'hF);
    acc(1'b1, 8'h20, 32'h1, 4'hF);
    chk("w1c_ack", {127'b0, a1}, 128'd1);
    acc(1'b1, 8'h20, 32'hFF, 4'b1110);
    acc(1'b0, 8'h20, 32'h0, 4'hF);
    chk("w1c_rd", {96'b0, d1}, 128'h8);

    // invalid addresses
    acc(1'b1, 8'h15, 32'hFFFFFFFF, 4'hF);
    chk("mis_err", {127'b0, e1}, 128'd1);
    chk("mis_ack", {127'b0, a1}, 128'd0);
    chk("mis_upd", {124'b0, u1}, 128'd0);
    chk("mis_err_n2", {127'b0, e2}, 128'd0);
    chk("mis_fab", f1, {32'hCAFE0003, RV, 32'hDE22BE44, 32'h1234});
    acc(1'b0, 8'h24, 32'h0, 4'hF);
    chk("oor_err", {127'b0, e1}, 128'd1);
    chk("oor_ack", {127'b0, a1}, 128'd0);
    chk("oor_dat", {96'b0, d1}, 128'h0);
    acc(1'b1, 8'h0C, 32'hFFFFFFFF, 4'hF);
    chk("low_err", {127'b0, e1}, 128'd1);
    chk("low_ack", {127'b0, a1}, 128'd0);
    chk("low_fab", f1, {32'hCAFE0003, RV, 32'hDE22BE44, 32'h1234});
    acc(1'b0, 8'h20, 32'h0, 4'hF);
    chk("err_st", {96'b0, d1}, 128'h0);

    // strobe held high: one response every 2 cycles
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 8'h14; sel = 4'hF;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk("b2b_ack", {127'b0, ack}, {127'b0, (i % 2) == 0});
      chk("b2b_dat", {96'b0, rdat},
          ((i % 2) == 0) ? {96'b0, 32'hDE22BE44} : 128'h0);
    end
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1;

    // async reset mid-cycle, aborting a pending write
    acc(1'b1, 8'h10, 32'h0000_0001, 4'hF);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 8'h10;
    wdat = 32'h77; sel = 4'hF;
    chk("pre_rst_int", {127'b0, irq}, 128'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_fab", fab, FAB_RST);
    chk("arst_int", {127'b0, irq}, 128'd0);
    chk("arst_ack", {127'b0, ack}, 128'd0);
    chk("arst_dat", {96'b0, rdat}, 128'd0);
    @(posedge clk); #1;
    chk("arst_fab_e", fab, FAB_RST);
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("abort_ack", {127'b0, ack}, 128'd0);
    chk("abort_err", {127'b0, err}, 128'd0);
    chk("abort_upd", {124'b0, upd}, 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
